nibble_serial_alu: RTL and testbench
====================================

# nibble_serial_alu

Area-reduced 12-bit add/subtract unit. It accepts a full operand pair through a valid/ready handshake and sequences the operation through one external 4-bit carry-lookahead adder slice, one nibble per cycle, LSB first. It registers the carry between nibbles, assembles the result, and returns the result plus C/V/Z flags through a valid/ready output handshake. It sits between the register-file read port and the datapath's single CLA slice. It drives that slice's operand and carry inputs and consumes its sum and carry-out.

## Interface
- WIDTH, 12, operand/result width; must be a multiple of 4 (NIB = WIDTH/4 nibble steps).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit idle and able to accept.
- op_sub  input  1  0 = A+B, 1 = A-B.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cla_a  output  4  nibble of A to CLA slice.
- cla_b  output  4  nibble of B (inverted for subtract) to CLA slice.
- cla_cin  output  1  carry into CLA slice.
- cla_s  input  4  sum from CLA slice (combinational, same cycle).
- cla_cout  input  1  carry-out from CLA slice.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
- flag_c  output  1  final carry-out; for subtract, 1 = no borrow.
- flag_v  output  1  two's-complement overflow.
- flag_z  output  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_in, b_in ^ {WIDTH{op_sub}}, and op_sub; carry_reg <= op_sub; cnt <= 0; go to RUN.
- RUN:
  - cla_a = A[4*cnt+3:4*cnt]; cla_b = Bx[4*cnt+3:4*cnt]; cla_cin = carry_reg.
  - Each edge: result[4*cnt+3:4*cnt] <= cla_s; carry_reg <= cla_cout; cnt <= cnt+1.
  - When cnt == NIB-1, go to DONE on that edge. flag_c <= cla_cout. flag_v <= (A[W-1] == Bx[W-1]) && (cla_s[3] != A[W-1]). flag_z <= (assembled result == 0), including the final nibble.
- DONE:
  - out_valid=1. result and flags are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- cla_a, cla_b, and cla_cin are driven 0 outside RUN.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and a_in/b_in are sampled only at acceptance.
- No overlap between operations: a new operand pair is accepted no earlier than the cycle after the result handshake.
- Arithmetic is unsigned modulo 2^WIDTH. V uses the two's-complement interpretation of A and the effective (possibly inverted) B.

## Timing
- Reset (rst_n=0 at an edge), from any state including mid-RUN:
  - State goes to IDLE. cnt, carry_reg, result, and all flags go to 0.
  - out_valid=0, in_ready=1, cla_* = 0.
  - A partial result is discarded and no out_valid is produced for it.
- Latency: accept at edge E0 (in_valid & in_ready). The RUN nibbles are captured at edges E1..E_NIB. out_valid is high in the cycle after E_NIB, which is 3 cycles after acceptance for WIDTH=12.
- Throughput with out_ready held at 1: one operation per NIB+2 cycles (accept, NIB RUN cycles, DONE cycle).
- The result handshake completes at the first edge with out_valid & out_ready. in_ready rises in the following cycle.
- The CLA slice is purely combinational, so cla_s/cla_cout must settle within the same cycle as cla_a/cla_b/cla_cin. There is no extra wait state.

## Test plan
- Add 0x0FF + 0x001 -> result 0x100, C=0, V=0, Z=0. out_valid rises exactly 3 cycles after acceptance, and cla_cin sequence is 0,1,1 (carry ripples across nibbles).
- Add 0xFFF + 0x001 -> 0x000, C=1, V=0, Z=1. Add 0x7FF + 0x001 -> 0x800, C=0, V=1, Z=0.
- Subtract 0x005 - 0x007 -> 0xFFE, C=0, V=0. Subtract 0x800 - 0x001 -> 0x7FF, C=1, V=1. Subtract 0x123 - 0x123 -> 0x000, Z=1, C=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing a_in -> result/flags unchanged, in_ready=0, no second acceptance. Then raising out_ready -> handshake, and in_ready=1 next cycle.
- Reset mid-operation: assert rst_n=0 during the second RUN cycle -> next cycle out_valid=0, result=0, flags 0, cla_*=0, in_ready=1. A subsequent 0x001+0x002 returns 0x003.
- Back-to-back with out_ready tied 1: 4 random operand pairs -> results match a reference model, with each out_valid 5 cycles apart.

Source files
------------

// File: rtl/nibble_serial_alu.sv
// Nibble-serial add/subtract unit. It drives one external 4-bit CLA slice, one nibble
// per cycle and LSB first, then returns the result with C/V/Z flags over valid/ready.
module nibble_serial_alu #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_s,
    input  logic             cla_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bx;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag_c;
    logic             r_flag_v;
    logic             r_flag_z;

    logic             w_last;
    logic [CNT_W+1:0] w_shift;
    logic [WIDTH-1:0] w_nib_mask;
    logic [WIDTH-1:0] w_result_next;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;

    assign w_last        = (r_cnt == LAST);
    assign w_shift       = {r_cnt, 2'b00};
    assign w_nib_a       = 4'(r_a >> w_shift);
    assign w_nib_b       = 4'(r_bx >> w_shift);
    assign w_nib_mask    = WIDTH'(4'hF) << w_shift;
    // The current nibble is merged in so the zero flag sees the final nibble too.
    assign w_result_next = (r_result & ~w_nib_mask) | (WIDTH'(cla_s) << w_shift);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: each variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cla_a     = 4'h0;
        cla_b     = 4'h0;
        cla_cin   = 1'b0;
        unique case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN: begin
                cla_a   = w_nib_a;
                cla_b   = w_nib_b;
                cla_cin = r_carry;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_bx     <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
                        r_a     <= a_in;
                        r_bx    <= b_in ^ {WIDTH{op_sub}};
                        r_carry <= op_sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= cla_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_flag_c <= cla_cout;
                        r_flag_v <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) && (cla_s[3] != r_a[WIDTH-1]);
                        r_flag_z <= (w_result_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flag_c = r_flag_c;
    assign flag_v = r_flag_v;
    assign flag_z = r_flag_z;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Self-checking bench for nibble_serial_alu: a behavioural CLA slice, table-driven
// vectors, hand-written corner sequences and a queue-based result scoreboard.
module tb_nibble_serial_alu;
    localparam int W = 12;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [3:0]   cla_a;
    logic [3:0]   cla_b;
    logic         cla_cin;
    logic [3:0]   cla_s;
    logic         cla_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;

    // Behavioural 4-bit adder slice, combinational.
    assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

    nibble_serial_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a_in(a_in), .b_in(b_in),
        .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
        .cla_s(cla_s), .cla_cout(cla_cout),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    int   checks;
    int   failures;
    int   cyc;
    int   hs_count;
    int   hs_cyc;
    exp_t exp_q[$];
    exp_t nxt_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   s;
        bx  = b ^ {W{sub}};
        s   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] == bx[W-1]) && (e.r[W-1] != a[W-1]);
        e.z = (e.r == '0);
        return e;
    endfunction

    // Called at a falling edge after inputs are set: records what the next rising edge does.
    task automatic tick();
        exp_t e;
        if (rst_n && in_valid && in_ready) exp_q.push_back(nxt_exp);
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual=0x%0h required=none", result);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", 32'(result), 32'(e.r));
                check("sb_flag_c", 32'(flag_c), 32'(e.c));
                check("sb_flag_v", 32'(flag_v), 32'(e.v));
                check("sb_flag_z", 32'(flag_z), 32'(e.z));
            end
            hs_count++;
            hs_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int n;
        int start;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_sub   = sub;
        a_in     = a;
        b_in     = b;
        nxt_exp  = e;
        start    = hs_count;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (hs_count == start && n < 20) begin
            tick();
            n++;
        end
        check("handshake_timeout", 32'(hs_count - start), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        int   prev_hs;
        logic sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   cin_seq;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        hs_count = 0;
        hs_cyc   = 0;
        nxt_exp  = '0;
        cin_seq  = 3'b110;

        vecs[0] = '{1'b0, 12'h0FF, 12'h001, '{12'h100, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{1'b0, 12'hFFF, 12'h001, '{12'h000, 1'b1, 1'b0, 1'b1}};
        vecs[2] = '{1'b0, 12'h7FF, 12'h001, '{12'h800, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{1'b1, 12'h005, 12'h007, '{12'hFFE, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{1'b1, 12'h800, 12'h001, '{12'h7FF, 1'b1, 1'b1, 1'b0}};
        vecs[5] = '{1'b1, 12'h123, 12'h123, '{12'h000, 1'b1, 1'b0, 1'b1}};
        vecs[6] = '{1'b0, 12'h555, 12'hAAA, '{12'hFFF, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{1'b1, 12'h000, 12'h000, '{12'h000, 1'b1, 1'b0, 1'b1}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op_sub   = vecs[i].sub;
            a_in     = vecs[i].a;
            b_in     = vecs[i].b;
            nxt_exp  = vecs[i].e;
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                check("run_in_ready", 32'(in_ready), 32'd0);
                check("run_out_valid", 32'(out_valid), 32'd0);
                check("run_cla_a", 32'(cla_a), 32'(vecs[i].a[4*k +: 4]));
                if (i == 0) check("carry_ripple_cin", 32'(cla_cin), 32'(cin_seq[k]));
                tick();
            end
            check("latency_out_valid", 32'(out_valid), 32'd1);
            tick();
            check("post_hs_in_ready", 32'(in_ready), 32'd1);
            check("post_hs_out_valid", 32'(out_valid), 32'd0);
        end

        // Backpressure: result held, no second acceptance, new operands ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_sub    = 1'b0;
        a_in      = 12'h0FF;
        b_in      = 12'h001;
        nxt_exp   = '{12'h100, 1'b0, 1'b0, 1'b0};
        tick();
        for (int k = 0; k < 3; k++) begin
            a_in = W'($urandom);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            a_in = W'($urandom);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_result", 32'(result), 32'h100);
            check("bp_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        prev_hs   = hs_count;
        tick();
        check("bp_handshake", 32'(hs_count - prev_hs), 32'd1);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_no_second_accept", 32'(exp_q.size()), 32'd0);

        // Reset during the second RUN cycle discards the partial operation.
        in_valid = 1'b1;
        op_sub   = 1'b0;
        a_in     = 12'h0FF;
        b_in     = 12'h001;
        nxt_exp  = '{12'h100, 1'b0, 1'b0, 1'b0};
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
        check("mid_rst_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("mid_rst_no_output", 32'(out_valid), 32'd0);
            tick();
        end
        do_op(1'b0, 12'h001, 12'h002, '{12'h003, 1'b0, 1'b0, 1'b0});

        // Back-to-back random operations with out_ready tied high.
        for (int n = 0; n < 4; n++) begin
            sub     = 1'($urandom);
            a       = W'($urandom);
            b       = W'($urandom);
            prev_hs = hs_cyc;
            do_op(sub, a, b, model(sub, a, b));
            if (n > 0) check("b2b_spacing", 32'(hs_cyc - prev_hs), 32'd5);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
